cp0_exc_unit: RTL and testbench
===============================

# cp0_exc_unit

Coprocessor-0 exception unit for the pipelined MIPS core. It consumes the 2-bit exception code produced by the exception detector for the instruction in the EX/MEM boundary stage, and merges it with synchronized hardware interrupts. It updates the Status, Cause and EPC registers, and issues a flush/redirect to the PC and pipeline-control logic. It also services mfc0/mtc0 accesses and eret.

## Interface
- No parameters. Exception vector is fixed at 32'h0000_4180.
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- exc_code  in  2  from exception detector: 2'd0 Int (no synchronous exception), 2'd1 Unimpl (reserved instruction), 2'd2 Ov (overflow); 2'd3 treated as Int
- instr_valid  in  1  stage holds a real (non-bubble) instruction
- exc_pc  in  32  PC of that instruction
- hw_int  in  6  asynchronous interrupt lines, active-high level
- eret  in  1  stage holds a valid eret
- cp0_we  in  1  mtc0 write strobe
- cp0_addr  in  5  register number for mfc0/mtc0
- cp0_wdata  in  32  mtc0 data
- cp0_rdata  out  32  mfc0 data, combinational from cp0_addr
- exc_flush  out  1  flush pipeline and redirect to exc_target
- exc_target  out  32  redirect PC: 32'h0000_4180 for exception/interrupt, EPC for eret
- status_out, cause_out, epc_out  out  32 each  live register values

## Operation
- **Status (12)**
  - [0] IE, [1] EXL, [15:10] IM.
  - Other bits read 0.
  - Reset 32'h0.
  - Fully writable via mtc0 in the implemented bits.
- **Cause (13)**
  - [15:10] IP hardware, read-only: synchronized hw_int.
  - [9:8] IP software, writable.
  - [6:2] ExcCode: Int→0, Unimpl→10, Ov→12.
  - [31] BD always 0.
  - Reset 32'h0.
- **EPC (14)**
  - Writable.
  - Reset 32'h0.
- **PRId (15)**
  - Constant 32'h0000_0001.
  - Other addresses read 0; writes to them are ignored.
- **Interrupt synchronizer:** 2-flop chain per hw_int bit, reset 0. Cause[15:10] equals the second flop.
- **Event evaluation:** every cycle in state RUN.
  - `sync_exc` = instr_valid & exc_code ∈ {1,2}.
  - `int_req` = instr_valid & IE & ~EXL & |(Cause[15:8] & {IM,2'b11}).
  - Priority: sync_exc > int_req > eret.
- **Take exception or interrupt:**
  - exc_flush=1, exc_target=vector.
  - At the edge: EXL←1; ExcCode←mapped code (0 for interrupt).
  - EPC←exc_pc only if EXL was 0; otherwise EPC is held.
- **Take eret** (instr_valid & eret):
  - exc_flush=1, exc_target=EPC.
  - At the edge: EXL←0.
- **mtc0 collision:** when any event is taken in the same cycle, the mtc0 write is dropped entirely.
- **mfc0 during a write:** reading a register written in the same cycle returns the pre-write value.
- **FSM states:**
  - RUN → FLUSH on any taken event.
  - FLUSH → RUN unconditionally.
  - In FLUSH: exc_flush=0, no events taken, mtc0 writes ignored. The stage contents are a squashed instruction.
- rst in any state forces RUN and resets all registers, including a mid-flush cycle.

## Timing
- exc_flush and exc_target are combinational in the decision cycle N.
- Register updates are visible from cycle N+1.
- exc_flush is never asserted in two consecutive cycles.
- hw_int to Cause.IP latency: 2 cycles. Earliest interrupt take is cycle 2 after the input rises, given IE=1, EXL=0, IM set and instr_valid.
- Reset values:
  - exc_flush=0
  - exc_target=32'h0000_4180 (Status/EPC zero)
  - cp0_rdata: per the 0 registers
  - all *_out: 0

## Test plan
- Reset, then mfc0 of 12/13/14/15 → 0, 0, 0, 32'h0000_0001.
- exc_code=2, instr_valid=1, exc_pc=32'h0000_3010, EXL=0 → exc_flush=1 with target 32'h0000_4180 that cycle; next cycle EPC=32'h3010, Cause[6:2]=12, Status[1]=1, exc_flush=0.
- Status=32'h0000_0401 (IE=1, IM[0]=1); hw_int[0] rises → no take for 2 cycles; take in cycle 2 with Cause[6:2]=0, EPC=exc_pc. The same sequence with EXL=1 → no take.
- exc_code=1 while EXL=1, exc_pc=32'h0000_5000 → flush to vector, Cause[6:2]=10, EPC unchanged.
- eret with EPC=32'h0000_3014 → exc_flush=1, target 32'h0000_3014, EXL cleared next cycle. An eret or exc_code=2 in the following FLUSH cycle is ignored.
- mtc0 to EPC with value 32'hDEAD_BEEF coinciding with exc_code=2, exc_pc=32'h100 → EPC=32'h100. An mtc0 alone with the same value → EPC=32'hDEAD_BEEF. A same-cycle mfc0 returns the old value.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception unit: Status/Cause/EPC/PRId registers, interrupt synchronizer,
// exception/interrupt/eret arbitration and a one-cycle flush FSM.
module cp0_exc_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  exc_code,
  input  logic        instr_valid,
  input  logic [31:0] exc_pc,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        exc_flush,
  output logic [31:0] exc_target,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out
);

  localparam logic [31:0] ExcVector  = 32'h0000_4180;
  localparam logic [31:0] PridValue  = 32'h0000_0001;
  localparam logic [4:0]  AddrStatus = 5'd12;
  localparam logic [4:0]  AddrCause  = 5'd13;
  localparam logic [4:0]  AddrEpc    = 5'd14;
  localparam logic [4:0]  AddrPrid   = 5'd15;
  localparam logic [4:0]  CodeInt    = 5'd0;
  localparam logic [4:0]  CodeRi     = 5'd10;
  localparam logic [4:0]  CodeOv     = 5'd12;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e      state_q, state_d;
  logic [5:0]  int_sync1_q, int_sync2_q;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [5:0]  im_q, im_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        in_run;
  logic        sync_exc;
  logic        int_req;
  logic        take_exc;
  logic        take_eret;
  logic        take_any;
  logic        wr_ok;
  logic [4:0]  mapped_code;

  assign status_out = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_out  = {16'b0, int_sync2_q, ip_sw_q, 1'b0, cause_exc_q, 2'b0};
  assign epc_out    = epc_q;

  // Event arbitration: synchronous exception beats interrupt beats eret.
  always_comb begin
    in_run      = (state_q == StRun);
    sync_exc    = in_run & instr_valid & ((exc_code == 2'd1) | (exc_code == 2'd2));
    int_req     = in_run & instr_valid & ie_q & ~exl_q &
                  (|({int_sync2_q, ip_sw_q} & {im_q, 2'b11}));
    take_exc    = sync_exc | int_req;
    take_eret   = in_run & instr_valid & eret & ~take_exc;
    take_any    = take_exc | take_eret;
    wr_ok       = in_run & cp0_we & ~take_any;
    mapped_code = CodeInt;
    if (sync_exc) begin
      case (exc_code)
        2'd1:    mapped_code = CodeRi;
        2'd2:    mapped_code = CodeOv;
        default: mapped_code = CodeInt;
      endcase
    end
  end

  always_comb begin
    exc_flush  = take_any;
    exc_target = take_eret ? epc_q : ExcVector;
  end

  // mfc0 reads the current (pre-write) register contents.
  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      AddrStatus: cp0_rdata = status_out;
      AddrCause:  cp0_rdata = cause_out;
      AddrEpc:    cp0_rdata = epc_q;
      AddrPrid:   cp0_rdata = PridValue;
      default:    cp0_rdata = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ie_d        = ie_q;
    exl_d       = exl_q;
    im_d        = im_q;
    ip_sw_d     = ip_sw_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;

    if (wr_ok) begin
      case (cp0_addr)
        AddrStatus: begin
          ie_d  = cp0_wdata[0];
          exl_d = cp0_wdata[1];
          im_d  = cp0_wdata[15:10];
        end
        AddrCause: ip_sw_d = cp0_wdata[9:8];
        AddrEpc:   epc_d   = cp0_wdata;
        default:   ;
      endcase
    end

    // A nested exception (EXL already set) must keep the original return address.
    if (take_exc) begin
      exl_d       = 1'b1;
      cause_exc_d = mapped_code;
      if (!exl_q) begin
        epc_d = exc_pc;
      end
    end else if (take_eret) begin
      exl_d = 1'b0;
    end

    unique case (state_q)
      StRun:   state_d = take_any ? StFlush : StRun;
      StFlush: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      int_sync1_q <= 6'b0;
      int_sync2_q <= 6'b0;
      ie_q        <= 1'b0;
      exl_q       <= 1'b0;
      im_q        <= 6'b0;
      ip_sw_q     <= 2'b0;
      cause_exc_q <= 5'b0;
      epc_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      int_sync1_q <= hw_int;
      int_sync2_q <= int_sync1_q;
      ie_q        <= ie_d;
      exl_q       <= exl_d;
      im_q        <= im_d;
      ip_sw_q     <= ip_sw_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_cp0_exc_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  exc_code;
  logic        instr_valid;
  logic [31:0] exc_pc;
  logic [5:0]  hw_int;
  logic        eret;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_flush;
  logic [31:0] exc_target;
  logic [31:0] status_out;
  logic [31:0] cause_out;
  logic [31:0] epc_out;

  cp0_exc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .exc_code   (exc_code),
    .instr_valid(instr_valid),
    .exc_pc     (exc_pc),
    .hw_int     (hw_int),
    .eret       (eret),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .exc_flush  (exc_flush),
    .exc_target (exc_target),
    .status_out (status_out),
    .cause_out  (cause_out),
    .epc_out    (epc_out)
  );

  localparam logic [31:0] V = 32'h0000_4180;

  typedef struct {
    int          idx;
    logic        fl;
    logic [31:0] tg;
    logic [31:0] st;
    logic [31:0] ca;
    logic [31:0] ep;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_fail;
  int   n_issued;
  logic prev_flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int idx, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL v%0d %s: got %h want %h", idx, nm, act, exp);
      n_fail++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      chk(e.idx, "exc_flush", {31'b0, exc_flush}, {31'b0, e.fl});
      chk(e.idx, "exc_target", exc_target, e.tg);
      chk(e.idx, "status", status_out, e.st);
      chk(e.idx, "cause", cause_out, e.ca);
      chk(e.idx, "epc", epc_out, e.ep);
      chk(e.idx, "cp0_rdata", cp0_rdata, e.rd);
      if (exc_flush && prev_flush) begin
        $display("FAIL v%0d back_to_back_flush: got 1 want 0", e.idx);
        n_fail++;
      end
    end
    prev_flush = exc_flush;
  end

  task automatic vec(input logic r, input logic iv, input logic [1:0] code,
                     input logic [31:0] pc, input logic [5:0] hw, input logic er,
                     input logic we, input logic [4:0] ad, input logic [31:0] wd,
                     input logic efl, input logic [31:0] etg, input logic [31:0] est,
                     input logic [31:0] eca, input logic [31:0] eep, input logic [31:0] erd);
    exp_t e;
    rst         = r;
    instr_valid = iv;
    exc_code    = code;
    exc_pc      = pc;
    hw_int      = hw;
    eret        = er;
    cp0_we      = we;
    cp0_addr    = ad;
    cp0_wdata   = wd;
    n_issued++;
    e.idx = n_issued;
    e.fl  = efl;
    e.tg  = etg;
    e.st  = est;
    e.ca  = eca;
    e.ep  = eep;
    e.rd  = erd;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec       = 0;
    n_fail      = 0;
    n_issued    = 0;
    prev_flush  = 1'b0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    exc_code    = 2'd0;
    exc_pc      = 32'h0;
    hw_int      = 6'h0;
    eret        = 1'b0;
    cp0_we      = 1'b0;
    cp0_addr    = 5'd0;
    cp0_wdata   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    //   r iv cd pc            hw er we ad  wdata          fl tgt  status        cause         epc           rdata
    vec(0, 0, 0, 32'h0,        0, 0, 0, 12, 32'h0,         0, V, 32'h0,        32'h0,        32'h0,        32'h0);
    vec(0, 0, 0, 32'h0,        0, 0, 0, 13, 32'h0,         0, V, 32'h0,        32'h0,        32'h0,        32'h0);
    vec(0, 0, 0, 32'h0,        0, 0, 0, 14, 32'h0,         0, V, 32'h0,        32'h0,        32'h0,        32'h0);
    vec(0, 0, 0, 32'h0,        0, 0, 0, 15, 32'h0,         0, V, 32'h0,        32'h0,        32'h0,        32'h1);
    vec(0, 0, 0, 32'h0,        0, 0, 0, 16, 32'h0,         0, V, 32'h0,        32'h0,        32'h0,        32'h0);
    // Overflow with EXL=0, then nested reserved-instruction with EXL=1.
    vec(0, 1, 2, 32'h3010,     0, 0, 0, 0,  32'h0,         1, V, 32'h0,        32'h0,        32'h0,        32'h0);
    vec(0, 0, 0, 32'h0,        0, 0, 0, 13, 32'h0,         0, V, 32'h2,        32'h30,       32'h3010,     32'h30);
    vec(0, 1, 1, 32'h5000,     0, 0, 0, 0,  32'h0,         1, V, 32'h2,        32'h30,       32'h3010,     32'h0);
    vec(0, 1, 2, 32'h0,        0, 1, 0, 0,  32'h0,         0, V, 32'h2,        32'h28,       32'h3010,     32'h0);
    // eret to 3014, with an eret in the following flush cycle ignored.
    vec(0, 0, 0, 32'h0,        0, 0, 1, 14, 32'h3014,      0, V, 32'h2,        32'h28,       32'h3010,     32'h3010);
    vec(0, 1, 0, 32'h0,        0, 1, 0, 0,  32'h0,         1, 32'h3014, 32'h2, 32'h28,       32'h3014,     32'h0);
    vec(0, 1, 0, 32'h0,        0, 1, 0, 0,  32'h0,         0, V, 32'h0,        32'h28,       32'h3014,     32'h0);
    // Hardware interrupt 0 through the synchronizer.
    vec(0, 0, 0, 32'h0,        0, 0, 1, 12, 32'h401,       0, V, 32'h0,        32'h28,       32'h3014,     32'h0);
    vec(0, 1, 0, 32'h200,      1, 0, 0, 0,  32'h0,         0, V, 32'h401,      32'h28,       32'h3014,     32'h0);
    vec(0, 1, 0, 32'h200,      1, 0, 0, 0,  32'h0,         0, V, 32'h401,      32'h28,       32'h3014,     32'h0);
    vec(0, 1, 0, 32'h200,      1, 0, 0, 0,  32'h0,         1, V, 32'h401,      32'h428,      32'h3014,     32'h0);
    vec(0, 1, 0, 32'h200,      1, 0, 0, 0,  32'h0,         0, V, 32'h403,      32'h400,      32'h200,      32'h0);
    vec(0, 1, 0, 32'h200,      1, 0, 0, 0,  32'h0,         0, V, 32'h403,      32'h400,      32'h200,      32'h0);
    vec(0, 1, 0, 32'h200,      0, 0, 0, 0,  32'h0,         0, V, 32'h403,      32'h400,      32'h200,      32'h0);
    vec(0, 1, 0, 32'h200,      0, 0, 0, 0,  32'h0,         0, V, 32'h403,      32'h400,      32'h200,      32'h0);
    // mtc0 collision with an overflow, then mtc0 alone.
    vec(0, 0, 0, 32'h0,        0, 0, 1, 12, 32'h401,       0, V, 32'h403,      32'h0,        32'h200,      32'h403);
    vec(0, 1, 2, 32'h100,      0, 0, 1, 14, 32'hDEADBEEF,  1, V, 32'h401,      32'h0,        32'h200,      32'h200);
    vec(0, 0, 0, 32'h0,        0, 0, 1, 14, 32'hDEADBEEF,  0, V, 32'h403,      32'h30,       32'h100,      32'h100);
    vec(0, 0, 0, 32'h0,        0, 0, 1, 14, 32'hDEADBEEF,  0, V, 32'h403,      32'h30,       32'h100,      32'h100);
    vec(0, 0, 0, 32'h0,        0, 0, 0, 14, 32'h0,         0, V, 32'h403,      32'h30,       32'hDEADBEEF, 32'hDEADBEEF);
    // Write masks, then a software interrupt.
    vec(0, 0, 0, 32'h0,        0, 0, 1, 13, 32'hFFFFFFFF,  0, V, 32'h403,      32'h30,       32'hDEADBEEF, 32'h30);
    vec(0, 0, 0, 32'h0,        0, 0, 1, 12, 32'hFFFFFFFF,  0, V, 32'h403,      32'h330,      32'hDEADBEEF, 32'h403);
    vec(0, 0, 0, 32'h0,        0, 0, 1, 12, 32'hFC01,      0, V, 32'hFC03,     32'h330,      32'hDEADBEEF, 32'hFC03);
    vec(0, 1, 0, 32'h300,      0, 0, 0, 15, 32'h0,         1, V, 32'hFC01,     32'h330,      32'hDEADBEEF, 32'h1);
    vec(0, 0, 0, 32'h0,        0, 0, 0, 0,  32'h0,         0, V, 32'hFC03,     32'h300,      32'h300,      32'h0);
    // Exception beats eret; code 3 and bubbles take nothing.
    vec(0, 1, 1, 32'h400,      0, 1, 0, 0,  32'h0,         1, V, 32'hFC03,     32'h300,      32'h300,      32'h0);
    vec(0, 0, 0, 32'h0,        0, 0, 1, 16, 32'h123,       0, V, 32'hFC03,     32'h328,      32'h300,      32'h0);
    vec(0, 1, 3, 32'h0,        0, 0, 0, 0,  32'h0,         0, V, 32'hFC03,     32'h328,      32'h300,      32'h0);
    vec(0, 0, 2, 32'h0,        0, 0, 0, 0,  32'h0,         0, V, 32'hFC03,     32'h328,      32'h300,      32'h0);
    // Reset in the middle of a flush cycle.
    vec(0, 1, 2, 32'h500,      0, 0, 0, 0,  32'h0,         1, V, 32'hFC03,     32'h328,      32'h300,      32'h0);
    vec(1, 1, 2, 32'h0,        0, 0, 0, 0,  32'h0,         0, V, 32'hFC03,     32'h330,      32'h300,      32'h0);
    vec(0, 0, 0, 32'h0,        0, 0, 0, 12, 32'h0,         0, V, 32'h0,        32'h0,        32'h0,        32'h0);
    vec(0, 1, 2, 32'h600,      0, 0, 0, 0,  32'h0,         1, V, 32'h0,        32'h0,        32'h0,        32'h0);
    vec(0, 0, 0, 32'h0,        0, 0, 0, 14, 32'h0,         0, V, 32'h2,        32'h30,       32'h600,      32'h600);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", sb.size());
      n_fail++;
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
